apb_monitor: RTL

Synthesizable, always-on APB4 protocol monitor for a multi-slave APB segment. It watches the master-side select, enable and control signals and the per-slave PREADY/PSLVERR, and classifies every cycle as idle, setup or access. It records protocol violations in sticky flags, captures the first offending address, and keeps saturating transfer, error-response and worst-stall statistics. It sits passively beside the APB bridge or decoder, drives nothing onto the bus, and its outputs go to a CSR block or debug interrupt.

---
 rtl/apb_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_monitor.sv
// ---------------------------------------------------------------------------
// apb_monitor
//
// Passive APB4 protocol monitor for a multi-slave APB segment. Every bus cycle
// is classified against an expectation FSM (idle/setup vs. access). Protocol
// violations are collected in sticky flags, the first offending address and
// violation code are captured, and saturating statistics are kept for
// completed transfers, error responses and the longest access-phase stall.
// The block only observes the bus; it never drives any APB signal.
//
// Ports:
//   PCLK, PRESET          bus clock, asynchronous active-high reset
//   PSEL[NS]              one-hot slave selects (lowest set bit is used)
//   PENABLE               access phase
//   PADDR, PWRITE, PWDATA, PSTRB, PPROT   master-side control and data
//   PREADY[NS], PSLVERR[NS]               per-slave responses
//   i_clear               clears sticky flags, capture and statistics
//   o_err[8]              sticky violation flags (bit number = code)
//   o_err_any             OR of o_err
//   o_first_code          code of the first recorded violation
//   o_first_addr          PADDR of the cycle with the first violation
//   o_xfer_count          completed transfers (saturating)
//   o_slverr_count        completed transfers with PSLVERR (saturating)
//   o_max_stall           longest access-phase stall (saturating)
//
// Violation codes:
//   0 MULTISEL  1 SETUP  2 ACCESS  3 HOLD  4 DROP  5 TIMEOUT  6 SLVERR  7 RDSTRB
// ---------------------------------------------------------------------------
module apb_monitor #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NS         = 4,
    parameter int MAXSTALL   = 16,
    parameter int OPT_SLVERR = 1,
    parameter int CW         = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [NS-1:0]   PSEL,
    input  logic            PENABLE,
    input  logic [AW-1:0]   PADDR,
    input  logic            PWRITE,
    input  logic [DW-1:0]   PWDATA,
    input  logic [DW/8-1:0] PSTRB,
    input  logic [2:0]      PPROT,
    input  logic [NS-1:0]   PREADY,
    input  logic [NS-1:0]   PSLVERR,
    input  logic            i_clear,
    output logic [7:0]      o_err,
    output logic            o_err_any,
    output logic [2:0]      o_first_code,
    output logic [AW-1:0]   o_first_addr,
    output logic [CW-1:0]   o_xfer_count,
    output logic [CW-1:0]   o_slverr_count,
    output logic [CW-1:0]   o_max_stall
);

    localparam int            IW      = (NS > 1) ? $clog2(NS) : 1;
    localparam int            SW      = DW / 8;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit            TO_EN   = (MAXSTALL > 0);
    localparam bit            SLVERR_ALWAYS = (OPT_SLVERR == 0);

    typedef enum logic [0:0] {
        EXP_IDLE   = 1'b0,
        EXP_ACCESS = 1'b1
    } exp_state_t;

    // Index of the lowest set select bit; 0 when nothing is selected.
    function automatic logic [IW-1:0] lowest_sel(input logic [NS-1:0] v);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = NS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Priority encoder for violation codes: the lowest set bit wins.
    function automatic logic [2:0] lowest_code(input logic [7:0] v);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                code = 3'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // Saturating increment shared by all statistics counters.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Registered state
    exp_state_t    state_r;
    logic [IW-1:0] idx_r;
    logic [AW-1:0] paddr_r;
    logic          pwrite_r;
    logic [2:0]    pprot_r;
    logic [DW-1:0] pwdata_r;
    logic [SW-1:0] pstrb_r;
    logic [CW-1:0] stall_r;
    logic          to_fired_r;
    logic [7:0]    err_r;
    logic          err_any_r;
    logic [2:0]    code_r;
    logic [AW-1:0] addr_r;
    logic [CW-1:0] xfer_r;
    logic [CW-1:0] slverr_cnt_r;
    logic [CW-1:0] max_stall_r;

    // Combinational decode
    logic          any_sel_s;
    logic          multi_sel_s;
    logic [IW-1:0] sel_idx_s;
    logic          ready_s;
    logic          slverr_s;
    logic          access_s;
    logic          done_s;
    logic          stall_s;
    logic          same_s;
    logic          hold_chg_s;
    logic          in_access_s;
    logic [CW-1:0] stall_inc_s;
    logic          timeout_s;
    logic          stall_clr_s;
    logic [7:0]    viol_s;
    logic          resync_s;
    logic [7:0]    err_nxt_s;
    logic          capture_s;
    logic [CW-1:0] xfer_base_s;
    logic [CW-1:0] slverr_base_s;
    logic [CW-1:0] max_base_s;
    logic [CW-1:0] xfer_nxt_s;
    logic [CW-1:0] slverr_nxt_s;
    logic [CW-1:0] max_nxt_s;

    // Bus cycle decode: selected slave, its response and the cycle class.
    always_comb begin
        any_sel_s   = |PSEL;
        multi_sel_s = (PSEL & (PSEL - NS'(1))) != {NS{1'b0}};
        sel_idx_s   = lowest_sel(PSEL);
        ready_s     = any_sel_s & PREADY[sel_idx_s];
        slverr_s    = any_sel_s & PSLVERR[sel_idx_s];
        access_s    = any_sel_s & PENABLE;
        done_s      = access_s & ready_s;
        stall_s     = access_s & ~ready_s;
        same_s      = any_sel_s & (sel_idx_s == idx_r);
        in_access_s = (state_r == EXP_ACCESS);
        // Write data and strobes only have to be stable on writes.
        hold_chg_s  = (PADDR != paddr_r) | (PWRITE != pwrite_r) | (PPROT != pprot_r) |
                      (PWRITE & ((PWDATA != pwdata_r) | (PSTRB != pstrb_r)));
    end

    // Stall tracking: timeout fires on the stall cycle that brings the count
    // to MAXSTALL, and at most once until the transfer ends or is dropped.
    always_comb begin
        stall_inc_s = sat_inc(stall_r);
        timeout_s   = TO_EN & stall_s & ~to_fired_r & (32'(stall_inc_s) >= 32'(MAXSTALL));
        stall_clr_s = done_s | (in_access_s & ~same_s) | ~access_s;
    end

    // Violation vector for the current cycle.
    always_comb begin
        viol_s    = 8'h00;
        viol_s[0] = multi_sel_s;
        viol_s[1] = ~in_access_s & any_sel_s & PENABLE;
        viol_s[2] = in_access_s & same_s & ~PENABLE;
        viol_s[3] = in_access_s & hold_chg_s;
        viol_s[4] = in_access_s & ~same_s;
        viol_s[5] = timeout_s;
        if (SLVERR_ALWAYS) begin
            viol_s[6] = slverr_s;
        end else begin
            viol_s[6] = slverr_s & ~done_s;
        end
        viol_s[7] = any_sel_s & ~PWRITE & (PSTRB != {SW{1'b0}});
        resync_s  = viol_s[1] | viol_s[2] | viol_s[4];
    end

    // Next values for flags and statistics; a clear zeroes the base value and
    // the current cycle's events are then applied on top of it.
    always_comb begin
        if (i_clear) begin
            err_nxt_s     = viol_s;
            capture_s     = (viol_s != 8'h00);
            xfer_base_s   = {CW{1'b0}};
            slverr_base_s = {CW{1'b0}};
            max_base_s    = {CW{1'b0}};
        end else begin
            err_nxt_s     = err_r | viol_s;
            capture_s     = (viol_s != 8'h00) & ~err_any_r;
            xfer_base_s   = xfer_r;
            slverr_base_s = slverr_cnt_r;
            max_base_s    = max_stall_r;
        end
        if (done_s) begin
            xfer_nxt_s = sat_inc(xfer_base_s);
        end else begin
            xfer_nxt_s = xfer_base_s;
        end
        if (done_s & slverr_s) begin
            slverr_nxt_s = sat_inc(slverr_base_s);
        end else begin
            slverr_nxt_s = slverr_base_s;
        end
        if (done_s & (stall_r > max_base_s)) begin
            max_nxt_s = stall_r;
        end else begin
            max_nxt_s = max_base_s;
        end
    end

    // Expectation FSM with the index of the slave whose access phase is due.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= EXP_IDLE;
            idx_r   <= {IW{1'b0}};
        end else if (resync_s) begin
            // Re-derive the expectation from what the bus is doing right now.
            idx_r <= sel_idx_s;
            if (any_sel_s & (~PENABLE | ~ready_s)) begin
                state_r <= EXP_ACCESS;
            end else begin
                state_r <= EXP_IDLE;
            end
        end else begin
            case (state_r)
                EXP_IDLE: begin
                    if (any_sel_s & ~PENABLE) begin
                        state_r <= EXP_ACCESS;
                        idx_r   <= sel_idx_s;
                    end else begin
                        state_r <= EXP_IDLE;
                    end
                end
                EXP_ACCESS: begin
                    if (ready_s) begin
                        state_r <= EXP_IDLE;
                    end else begin
                        state_r <= EXP_ACCESS;
                    end
                end
                default: begin
                    state_r <= EXP_IDLE;
                end
            endcase
        end
    end

    // Previous-cycle copies of the control and data signals for hold checks.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_r  <= {AW{1'b0}};
            pwrite_r <= 1'b0;
            pprot_r  <= 3'd0;
            pwdata_r <= {DW{1'b0}};
            pstrb_r  <= {SW{1'b0}};
        end else begin
            paddr_r  <= PADDR;
            pwrite_r <= PWRITE;
            pprot_r  <= PPROT;
            pwdata_r <= PWDATA;
            pstrb_r  <= PSTRB;
        end
    end

    // Access-phase stall counter and the once-per-transfer timeout latch.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            stall_r    <= {CW{1'b0}};
            to_fired_r <= 1'b0;
        end else if (stall_clr_s) begin
            stall_r    <= {CW{1'b0}};
            to_fired_r <= 1'b0;
        end else begin
            stall_r <= stall_inc_s;
            if (timeout_s) begin
                to_fired_r <= 1'b1;
            end else begin
                to_fired_r <= to_fired_r;
            end
        end
    end

    // Sticky flags and first-violation capture.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_r     <= 8'h00;
            err_any_r <= 1'b0;
            code_r    <= 3'd0;
            addr_r    <= {AW{1'b0}};
        end else begin
            err_r     <= err_nxt_s;
            err_any_r <= |err_nxt_s;
            if (capture_s) begin
                code_r <= lowest_code(viol_s);
                addr_r <= PADDR;
            end else if (i_clear) begin
                code_r <= 3'd0;
                addr_r <= {AW{1'b0}};
            end else begin
                code_r <= code_r;
                addr_r <= addr_r;
            end
        end
    end

    // Saturating transfer, error-response and worst-stall statistics.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            xfer_r       <= {CW{1'b0}};
            slverr_cnt_r <= {CW{1'b0}};
            max_stall_r  <= {CW{1'b0}};
        end else begin
            xfer_r       <= xfer_nxt_s;
            slverr_cnt_r <= slverr_nxt_s;
            max_stall_r  <= max_nxt_s;
        end
    end

    assign o_err          = err_r;
    assign o_err_any      = err_any_r;
    assign o_first_code   = code_r;
    assign o_first_addr   = addr_r;
    assign o_xfer_count   = xfer_r;
    assign o_slverr_count = slverr_cnt_r;
    assign o_max_stall    = max_stall_r;

endmodule
